// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch-predictor counter encodings, the
// saturating 2-bit counter helpers and default predictor index widths.
// No ports; imported by the predictor files.
package rv32i_types;

  // Direction counter: bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    strongly_not_taken = 2'b00,
    weakly_not_taken   = 2'b01,
    weakly_taken       = 2'b10,
    strongly_taken     = 2'b11
  } br_pred;

  // Tournament chooser: bit 1 set selects the global component.
  typedef enum logic [1:0] {
    use_lc_predictor_1 = 2'b00,
    use_lc_predictor_2 = 2'b01,
    use_gl_predictor_1 = 2'b10,
    use_gl_predictor_2 = 2'b11
  } tn_predictor;

  localparam int unsigned BP_LC_IDX_BITS = 6;
  localparam int unsigned BP_GL_IDX_BITS = 8;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    return (v == 2'b00) ? v : v - 2'b01;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Flop array of 2-bit saturating counters, 2**IDX_BITS deep.
// Ports: clk/rst (sync, active-high, loads RST_VAL everywhere), one
// combinational read port (rd_idx -> rd_val), one update port (wr_idx with
// wr_inc / wr_dec saturating step, inc wins if both are raised).
module bp_counter_table
  import rv32i_types::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter logic [1:0]  RST_VAL  = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_val,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_inc,
  input  logic                wr_dec
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0] cnt_q [DEPTH];
  logic [1:0] wr_val_d;

  // Read sees the pre-update contents; no write-to-read bypass.
  assign rd_val = cnt_q[rd_idx];

  always_comb begin
    wr_val_d = cnt_q[wr_idx];
    if (wr_inc) begin
      wr_val_d = sat_inc2(cnt_q[wr_idx]);
    end else if (wr_dec) begin
      wr_val_d = sat_dec2(cnt_q[wr_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= RST_VAL;
      end
    end else if (wr_inc || wr_dec) begin
      cnt_q[wr_idx] <= wr_val_d;
    end
  end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch direction predictor: local table, gshare global table,
// per-PC chooser; combinational prediction, trained on resolved branches.
// Ports: pc_fetch -> predict_* (same cycle); upd_* trains at next edge;
// perf_branches / perf_mispredicts count resolved / mispredicted branches.
module tournament_predictor
  import rv32i_types::*;
#(
  parameter int unsigned LC_IDX_BITS = BP_LC_IDX_BITS,
  parameter int unsigned GL_IDX_BITS = BP_GL_IDX_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc_fetch,
  output logic                   predict_taken,
  output logic                   predict_lc_dir,
  output logic                   predict_gl_dir,
  output logic [GL_IDX_BITS-1:0] predict_ghr,
  input  logic                   upd_valid,
  input  logic [31:0]            upd_pc,
  input  logic                   upd_taken,
  input  logic                   upd_lc_dir,
  input  logic                   upd_gl_dir,
  input  logic [GL_IDX_BITS-1:0] upd_ghr,
  input  logic                   upd_mispredict,
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts
);

  logic [GL_IDX_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]            br_cnt_q, br_cnt_d;
  logic [31:0]            miss_cnt_q, miss_cnt_d;

  logic [LC_IDX_BITS-1:0] fetch_lidx, upd_lidx;
  logic [GL_IDX_BITS-1:0] fetch_gidx, upd_gidx;
  logic [1:0]             lc_val, gl_val, ch_val;
  logic                   tbl_inc, tbl_dec, ch_inc, ch_dec;
  logic                   unused_pc_bits;

  assign fetch_lidx = pc_fetch[LC_IDX_BITS+1:2];
  assign fetch_gidx = pc_fetch[GL_IDX_BITS+1:2] ^ ghr_q;
  assign upd_lidx   = upd_pc[LC_IDX_BITS+1:2];
  // Training uses the history the branch was predicted with, not the
  // current one, so the same entry that predicted it gets trained.
  assign upd_gidx   = upd_pc[GL_IDX_BITS+1:2] ^ upd_ghr;

  // Byte-offset and upper PC bits do not take part in any index.
  assign unused_pc_bits = ^{pc_fetch, upd_pc};

  assign tbl_inc = upd_valid & upd_taken;
  assign tbl_dec = upd_valid & ~upd_taken;

  // Chooser moves only when exactly one component was right:
  // toward local (down) when local alone was right, toward global (up)
  // when global alone was right.
  assign ch_dec = upd_valid & (upd_lc_dir == upd_taken) & (upd_gl_dir != upd_taken);
  assign ch_inc = upd_valid & (upd_lc_dir != upd_taken) & (upd_gl_dir == upd_taken);

  bp_counter_table #(
    .IDX_BITS(LC_IDX_BITS),
    .RST_VAL (weakly_not_taken)
  ) u_local (
    .clk   (clk),
    .rst   (rst),
    .rd_idx(fetch_lidx),
    .rd_val(lc_val),
    .wr_idx(upd_lidx),
    .wr_inc(tbl_inc),
    .wr_dec(tbl_dec)
  );

  bp_counter_table #(
    .IDX_BITS(GL_IDX_BITS),
    .RST_VAL (weakly_not_taken)
  ) u_global (
    .clk   (clk),
    .rst   (rst),
    .rd_idx(fetch_gidx),
    .rd_val(gl_val),
    .wr_idx(upd_gidx),
    .wr_inc(tbl_inc),
    .wr_dec(tbl_dec)
  );

  bp_counter_table #(
    .IDX_BITS(LC_IDX_BITS),
    .RST_VAL (use_lc_predictor_2)
  ) u_chooser (
    .clk   (clk),
    .rst   (rst),
    .rd_idx(fetch_lidx),
    .rd_val(ch_val),
    .wr_idx(upd_lidx),
    .wr_inc(ch_inc),
    .wr_dec(ch_dec)
  );

  assign predict_lc_dir = lc_val[1];
  assign predict_gl_dir = gl_val[1];
  assign predict_taken  = ch_val[1] ? gl_val[1] : lc_val[1];
  assign predict_ghr    = ghr_q;

  assign perf_branches    = br_cnt_q;
  assign perf_mispredicts = miss_cnt_q;

  always_comb begin
    ghr_d      = ghr_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd_valid) begin
      ghr_d    = {ghr_q[GL_IDX_BITS-2:0], upd_taken};
      br_cnt_d = br_cnt_q + 32'd1;
      if (upd_mispredict) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q      <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      ghr_q      <= ghr_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule
